// File: rtl/tlcd_bus_receiver.sv
// rtl/tlcd_bus_receiver.sv - LCD-side responder for the 16x2 text LCD write/read bus.
// Optional CGRAM storage: define TLCD_RX_CGRAM_EN.
module tlcd_bus_receiver #(
   parameter int BUSY_CYCLES  = 2000,
   parameter int CLEAR_CYCLES = 80000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       TLCD_E,
   input  logic       TLCD_RS,
   input  logic       TLCD_RW,
   input  logic [7:0] TLCD_DATA,
   output logic [7:0] TLCD_DATA_OUT,
   output logic       TLCD_DATA_OE,
   input  logic [4:0] RD_ADDR,
   output logic [7:0] RD_DATA,
   output logic       BUSY,
   output logic       DISP_ON,
   output logic       CMD_STROBE,
   output logic       DATA_STROBE,
   output logic       PROTOCOL_ERR
);

   localparam int TMAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_FILL = 2'd2;
   localparam logic [1:0] S_WAIT = 2'd3;

   logic          r_e_s1, r_e_s2, r_e_d;
   logic          r_rs_s1, r_rs_s2, r_rs_d;
   logic          r_rw_s1, r_rw_s2, r_rw_d;
   logic [7:0]    r_data_s1, r_data_s2, r_data_d;

   logic [1:0]    r_state;
   logic [TW-1:0] r_timer;
   logic [6:0]    r_fill;
   logic [6:0]    r_ac;
   logic          r_cg;
   logic          r_id;
   logic          r_disp;
   logic          r_perr;
   logic          r_rs_c, r_rw_c;
   logic [7:0]    r_data_c;
   logic [7:0]    r_dout;
   logic [7:0]    r_rd_data;
   logic [7:0]    r_ddram [0:79];

   logic          w_fall;
   logic          w_bf_read;
   logic          w_dd_ok;
   logic          w_wr_dd;
   logic [6:0]    w_dd_idx;
   logic [6:0]    w_rd_idx;
   logic [7:0]    w_cg_rd;
   logic [7:0]    w_ram_rd;

   // One step of the address counter, following the two 40-byte DDRAM rows.
   function automatic logic [6:0] f_ac_step(input logic [6:0] ac, input logic cg, input logic id);
      logic [6:0] n;
      n = id ? ac + 7'd1 : ac - 7'd1;
      if (cg)
         n = {1'b0, n[5:0]};
      else if (id && ac == 7'h27)
         n = 7'h40;
      else if (id && ac == 7'h67)
         n = 7'h00;
      else if (!id && ac == 7'h40)
         n = 7'h27;
      else if (!id && ac == 7'h00)
         n = 7'h67;
      return n;
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         {r_e_s1, r_e_s2, r_e_d}    <= 3'b000;
         {r_rs_s1, r_rs_s2, r_rs_d} <= 3'b000;
         {r_rw_s1, r_rw_s2, r_rw_d} <= 3'b000;
         r_data_s1 <= 8'h00;
         r_data_s2 <= 8'h00;
         r_data_d  <= 8'h00;
      end else begin
         r_e_s1    <= TLCD_E;
         r_e_s2    <= r_e_s1;
         r_e_d     <= r_e_s2;
         r_rs_s1   <= TLCD_RS;
         r_rs_s2   <= r_rs_s1;
         r_rs_d    <= r_rs_s2;
         r_rw_s1   <= TLCD_RW;
         r_rw_s2   <= r_rw_s1;
         r_rw_d    <= r_rw_s2;
         r_data_s1 <= TLCD_DATA;
         r_data_s2 <= r_data_s1;
         r_data_d  <= r_data_s2;
      end
   end

   // The *_d copies hold the bus as it was while synced E was still high.
   assign w_fall    = r_e_d & ~r_e_s2;
   assign w_bf_read = ~r_rs_d & r_rw_d;
   assign w_dd_ok   = (r_data_c[5:0] <= 6'h27);
   assign w_dd_idx  = r_ac[6] ? ({1'b0, r_ac[5:0]} + 7'd40) : r_ac;
   assign w_rd_idx  = RD_ADDR[4] ? ({3'b000, RD_ADDR[3:0]} + 7'd40) : {3'b000, RD_ADDR[3:0]};
   assign w_wr_dd   = (r_state == S_EXEC) & r_rs_c & ~r_rw_c & ~r_cg;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state  <= S_FILL;
         r_timer  <= '0;
         r_fill   <= 7'd0;
         r_ac     <= 7'd0;
         r_cg     <= 1'b0;
         r_id     <= 1'b1;
         r_disp   <= 1'b0;
         r_perr   <= 1'b0;
         r_rs_c   <= 1'b0;
         r_rw_c   <= 1'b0;
         r_data_c <= 8'h00;
      end else begin
         if (w_fall && !w_bf_read && r_state != S_IDLE)
            r_perr <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_fall && !w_bf_read) begin
                  r_rs_c   <= r_rs_d;
                  r_rw_c   <= r_rw_d;
                  r_data_c <= r_data_d;
                  r_state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_state <= S_WAIT;
               r_timer <= TW'(BUSY_CYCLES - 1);
               if (!r_rs_c && !r_rw_c) begin
                  casez (r_data_c)
                     8'b1???????: begin
                        r_ac <= w_dd_ok ? r_data_c[6:0] : 7'd0;
                        r_cg <= 1'b0;
                     end
                     8'b01??????: begin
                        r_ac <= {1'b0, r_data_c[5:0]};
                        r_cg <= 1'b1;
                     end
                     8'b00001???: r_disp <= r_data_c[2];
                     8'b000001??: r_id   <= r_data_c[1];
                     8'b0000001?: begin
                        r_ac <= 7'd0;
                        r_cg <= 1'b0;
                     end
                     8'b00000001: begin
                        r_ac    <= 7'd0;
                        r_cg    <= 1'b0;
                        r_id    <= 1'b1;
                        r_fill  <= 7'd0;
                        r_state <= S_FILL;
                     end
                     default: ;
                  endcase
               end else begin
                  r_ac <= f_ac_step(r_ac, r_cg, r_id);
               end
            end
            S_FILL: begin
               r_fill <= r_fill + 7'd1;
               if (r_fill == 7'd79) begin
                  r_state <= S_WAIT;
                  r_timer <= TW'(CLEAR_CYCLES - 1);
               end
            end
            default: begin
               if (r_timer == '0)
                  r_state <= S_IDLE;
               else
                  r_timer <= r_timer - 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (r_state == S_FILL)
         r_ddram[r_fill] <= 8'h20;
      else if (w_wr_dd)
         r_ddram[w_dd_idx] <= r_data_c;
   end

`ifdef TLCD_RX_CGRAM_EN
   logic       w_wr_cg;
   logic [7:0] r_cgram [0:63];

   assign w_wr_cg = (r_state == S_EXEC) & r_rs_c & ~r_rw_c & r_cg;

   always_ff @(posedge CLK) begin
      if (w_wr_cg)
         r_cgram[r_ac[5:0]] <= r_data_c;
   end

   assign w_cg_rd = r_cgram[r_ac[5:0]];
`else
   assign w_cg_rd = 8'h00;
`endif

   assign w_ram_rd = r_cg ? w_cg_rd : r_ddram[w_dd_idx];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_dout    <= 8'h00;
         r_rd_data <= 8'h00;
      end else begin
         r_rd_data <= r_ddram[w_rd_idx];
         if (r_e_s2 && r_rw_s2)
            r_dout <= r_rs_s2 ? w_ram_rd : {BUSY, r_ac};
      end
   end

   assign BUSY          = (r_state != S_IDLE);
   assign TLCD_DATA_OUT = r_dout;
   assign TLCD_DATA_OE  = r_e_s2 & r_e_d & r_rw_s2;
   assign RD_DATA       = r_rd_data;
   assign DISP_ON       = r_disp;
   assign PROTOCOL_ERR  = r_perr;
   assign CMD_STROBE    = (r_state == S_EXEC) & ~r_rs_c & ~r_rw_c;
   assign DATA_STROBE   = (r_state == S_EXEC) & r_rs_c & ~r_rw_c;

endmodule

// File: tb/tb_tlcd_bus_receiver.sv
// tb/tb_tlcd_bus_receiver.sv - table-driven and randomized bench for tlcd_bus_receiver.
// Expected CGRAM read data follows TLCD_RX_CGRAM_EN.
module tb_tlcd_bus_receiver;

   localparam int BC = 20;
   localparam int CC = 100;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       TLCD_E = 1'b0;
   logic       TLCD_RS = 1'b0;
   logic       TLCD_RW = 1'b0;
   logic [7:0] TLCD_DATA = 8'h00;
   logic [4:0] RD_ADDR = 5'd0;
   logic [7:0] TLCD_DATA_OUT;
   logic       TLCD_DATA_OE;
   logic [7:0] RD_DATA;
   logic       BUSY, DISP_ON, CMD_STROBE, DATA_STROBE, PROTOCOL_ERR;

   tlcd_bus_receiver #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
      .CLK(CLK), .RST(RST), .TLCD_E(TLCD_E), .TLCD_RS(TLCD_RS), .TLCD_RW(TLCD_RW),
      .TLCD_DATA(TLCD_DATA), .TLCD_DATA_OUT(TLCD_DATA_OUT), .TLCD_DATA_OE(TLCD_DATA_OE),
      .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .BUSY(BUSY), .DISP_ON(DISP_ON),
      .CMD_STROBE(CMD_STROBE), .DATA_STROBE(DATA_STROBE), .PROTOCOL_ERR(PROTOCOL_ERR)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_bad = 0;
   int cmd_cnt = 0;
   int dat_cnt = 0;

   always @(negedge CLK) begin
      if (CMD_STROBE) cmd_cnt++;
      if (DATA_STROBE) dat_cnt++;
   end

   // Reference model: LCD addresses used directly, rows joined as one 80-cell ring.
   logic [7:0] m_dd [0:127];
   logic [7:0] m_cg [0:63];
   bit         m_cg_ok [0:63];
   int         m_ac;
   bit         m_cgsel, m_id, m_disp;

   function automatic int lin(int a);
      return (a < 'h40) ? a : a - 'h40 + 40;
   endfunction

   function automatic int unlin(int p);
      return (p < 40) ? p : p - 40 + 'h40;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 128; i++) m_dd[i] = 8'h20;
      m_ac = 0; m_cgsel = 0; m_id = 1; m_disp = 0;
   endtask

   task automatic m_step();
      if (m_cgsel) m_ac = (m_ac + (m_id ? 1 : 63)) % 64;
      else         m_ac = unlin((lin(m_ac) + (m_id ? 1 : 79)) % 80);
   endtask

   // exp: predicted read data; known: 0 when the model cannot know it.
   task automatic m_apply(input bit rs, input bit rw, input int d, output int exp, output bit known);
      exp = 0; known = 1;
      if (!rs && rw) begin
         exp = m_ac;
      end else if (rs && rw) begin
         if (m_cgsel) begin
`ifdef TLCD_RX_CGRAM_EN
            exp = m_cg[m_ac]; known = m_cg_ok[m_ac];
`else
            exp = 0;
`endif
         end else exp = m_dd[m_ac];
         m_step();
      end else if (rs) begin
         if (m_cgsel) begin m_cg[m_ac] = d[7:0]; m_cg_ok[m_ac] = 1; end
         else m_dd[m_ac] = d[7:0];
         m_step();
      end else if (d >= 128) begin
         m_ac = ((d - 128) <= 'h27 || ((d - 128) >= 'h40 && (d - 128) <= 'h67)) ? d - 128 : 0;
         m_cgsel = 0;
      end else if (d >= 64) begin
         m_ac = d - 64; m_cgsel = 1;
      end else if (d >= 16) begin
      end else if (d >= 8) begin
         m_disp = d[2];
      end else if (d >= 4) begin
         m_id = d[1];
      end else if (d >= 2) begin
         m_ac = 0; m_cgsel = 0;
      end else if (d == 1) begin
         for (int i = 0; i < 128; i++) m_dd[i] = 8'h20;
         m_ac = 0; m_cgsel = 0; m_id = 1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic bus_xfer(input bit rs, input bit rw, input logic [7:0] d,
                           output logic [7:0] rd, output logic oe);
      @(negedge CLK);
      TLCD_RS = rs; TLCD_RW = rw; TLCD_DATA = d;
      @(negedge CLK);
      TLCD_E = 1'b1;
      repeat (5) @(negedge CLK);
      rd = TLCD_DATA_OUT; oe = TLCD_DATA_OE;
      TLCD_E = 1'b0;
      @(negedge CLK);
   endtask

   task automatic wait_idle();
      int k = 0;
      repeat (4) @(negedge CLK);
      while (BUSY && k < 1000) begin @(negedge CLK); k++; end
      if (k >= 1000) begin
         n_vec++; n_bad++;
         $display("FAIL busy_timeout: BUSY still 1 after %0d cycles, expected 0", k);
      end
   endtask

   task automatic do_op(input bit rs, input bit rw, input logic [7:0] d,
                        output logic [7:0] got, output logic oe, output int exp, output bit known);
      bus_xfer(rs, rw, d, got, oe);
      m_apply(rs, rw, d, exp, known);
      if (!(!rs && rw)) wait_idle();
   endtask

   task automatic rd_port(input int a, output logic [7:0] d);
      @(negedge CLK); RD_ADDR = a[4:0];
      @(negedge CLK); d = RD_DATA;
   endtask

   task automatic sweep(input string name);
      logic [7:0] d;
      for (int a = 0; a < 32; a++) begin
         rd_port(a, d);
         check($sformatf("%s_cell%0d", name, a), d, m_dd[(a < 16) ? a : 'h40 + a - 16]);
      end
   endtask

   task automatic measure_reset_busy(input string name);
      int cnt = 0;
      while (BUSY && cnt < 400) begin @(negedge CLK); cnt++; end
      n_vec++;
      if (cnt < 80 + CC || cnt > 80 + CC + 2) begin
         n_bad++;
         $display("FAIL %s: BUSY high %0d cycles, expected %0d..%0d", name, cnt, 80 + CC, 82 + CC);
      end
   endtask

   typedef struct {
      int         kind;   // 0 instr, 1 data wr, 2 busy rd, 3 data rd, 4 RD port, 5 DISP_ON
      logic [7:0] d;
      logic [7:0] e;
   } vec_t;

   function automatic vec_t v(int k, logic [7:0] d, logic [7:0] e);
      vec_t r;
      r.kind = k; r.d = d; r.e = e;
      return r;
   endfunction

   vec_t       tbl[$];
   logic [7:0] got;
   logic       oe;
   int         exp;
   bit         known;
   int         c0, d0;
   logic [7:0] cg_exp;

   initial begin
`ifdef TLCD_RX_CGRAM_EN
      cg_exp = 8'h1F;
`else
      cg_exp = 8'h00;
`endif
      tbl.push_back(v(0, 8'h80, 0)); tbl.push_back(v(1, 8'h41, 0)); tbl.push_back(v(1, 8'h42, 0));
      tbl.push_back(v(4, 0, 8'h41)); tbl.push_back(v(4, 1, 8'h42)); tbl.push_back(v(2, 0, 8'h02));
      tbl.push_back(v(0, 8'hA7, 0)); tbl.push_back(v(1, 8'h58, 0)); tbl.push_back(v(1, 8'h59, 0));
      tbl.push_back(v(4, 16, 8'h59)); tbl.push_back(v(2, 0, 8'h41));
      tbl.push_back(v(0, 8'h04, 0)); tbl.push_back(v(1, 8'h5A, 0));
      tbl.push_back(v(4, 17, 8'h5A)); tbl.push_back(v(2, 0, 8'h40)); tbl.push_back(v(0, 8'h06, 0));
      tbl.push_back(v(0, 8'h0C, 0)); tbl.push_back(v(5, 0, 8'h01));
      tbl.push_back(v(0, 8'h08, 0)); tbl.push_back(v(5, 0, 8'h00));
      tbl.push_back(v(0, 8'h48, 0)); tbl.push_back(v(1, 8'h1F, 0)); tbl.push_back(v(1, 8'h11, 0));
      tbl.push_back(v(0, 8'h48, 0)); tbl.push_back(v(3, 0, cg_exp)); tbl.push_back(v(2, 0, 8'h09));

      // Reset values while RST is held
      m_reset();
      repeat (3) @(negedge CLK);
      check("rst_busy", BUSY, 1);
      check("rst_oe", TLCD_DATA_OE, 0);
      check("rst_dout", TLCD_DATA_OUT, 8'h00);
      check("rst_rd_data", RD_DATA, 8'h00);
      check("rst_strobes", {CMD_STROBE, DATA_STROBE}, 2'b00);
      check("rst_perr", PROTOCOL_ERR, 0);
      RST = 1'b0;
      measure_reset_busy("reset_busy_len");
      sweep("reset");
      check("reset_disp", DISP_ON, 0);

      // Table-driven vectors
      c0 = cmd_cnt; d0 = dat_cnt;
      for (int i = 0; i < tbl.size(); i++) begin
         case (tbl[i].kind)
            0: do_op(0, 0, tbl[i].d, got, oe, exp, known);
            1: do_op(1, 0, tbl[i].d, got, oe, exp, known);
            2: begin
               do_op(0, 1, 8'h00, got, oe, exp, known);
               check($sformatf("tbl%0d_busyrd", i), {oe, got}, {1'b1, tbl[i].e});
            end
            3: begin
               do_op(1, 1, 8'h00, got, oe, exp, known);
               check($sformatf("tbl%0d_datard", i), {oe, got}, {1'b1, tbl[i].e});
            end
            4: begin
               rd_port(tbl[i].d, got);
               check($sformatf("tbl%0d_rdport", i), got, tbl[i].e);
            end
            default: check($sformatf("tbl%0d_disp", i), DISP_ON, tbl[i].e[0]);
         endcase
         if (i == 5) begin
            check("first_cmd_strobes", cmd_cnt - c0, 1);
            check("first_data_strobes", dat_cnt - d0, 2);
         end
      end
      check("tbl_cmd_strobes", cmd_cnt - c0, 8);
      check("tbl_data_strobes", dat_cnt - d0, 7);

      // Randomized operations against the model
      for (int i = 0; i < 60; i++) begin
         int op;
         op = $urandom_range(0, 7);
         case (op)
            0: do_op(0, 0, 8'h80 | 8'($urandom_range(0, 127)), got, oe, exp, known);
            1: do_op(1, 0, 8'($urandom_range(0, 255)), got, oe, exp, known);
            2: do_op(0, 0, 8'h04 | (8'($urandom_range(0, 1)) << 1), got, oe, exp, known);
            3: begin
               do_op(0, 1, 8'h00, got, oe, exp, known);
               check($sformatf("rnd%0d_busyrd", i), {oe, got}, {1'b1, 8'(exp)});
            end
            4: begin
               do_op(1, 1, 8'h00, got, oe, exp, known);
               if (known) check($sformatf("rnd%0d_datard", i), {oe, got}, {1'b1, 8'(exp)});
            end
            5: do_op(0, 0, 8'h40 | 8'($urandom_range(0, 63)), got, oe, exp, known);
            6: do_op(0, 0, 8'h02, got, oe, exp, known);
            default: do_op(0, 0, 8'($urandom_range(16, 63)), got, oe, exp, known);
         endcase
      end
      do_op(0, 1, 8'h00, got, oe, exp, known);
      check("rnd_final_ac", got, 8'(exp));
      sweep("rnd");

      // Write while busy: discarded, flags PROTOCOL_ERR
      do_op(0, 0, 8'h85, got, oe, exp, known);
      check("perr_before", PROTOCOL_ERR, 0);
      bus_xfer(1, 0, 8'h44, got, oe);
      m_apply(1, 0, 8'h44, exp, known);
      bus_xfer(1, 0, 8'h43, got, oe);
      bus_xfer(0, 1, 8'h00, got, oe);
      check("busy_bf_read", {oe, got}, 9'h186);
      wait_idle();
      check("perr_set", PROTOCOL_ERR, 1);
      sweep("perr");

      // Clear, then RST around fill index 40
      do_op(0, 0, 8'h0C, got, oe, exp, known);
      check("disp_on_set", DISP_ON, 1);
      bus_xfer(0, 0, 8'h01, got, oe);
      begin
         int k = 0;
         while (!BUSY && k < 20) begin @(negedge CLK); k++; end
         check("clear_busy_seen", BUSY, 1);
      end
      repeat (41) @(negedge CLK);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      m_reset();
      measure_reset_busy("midfill_busy_len");
      sweep("midfill");
      check("midfill_perr", PROTOCOL_ERR, 0);
      check("midfill_disp", DISP_ON, 0);
      bus_xfer(0, 1, 8'h00, got, oe);
      check("midfill_bf_read", {oe, got}, 9'h100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
